// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES key expansion, one schedule word per cycle,
// with a registered round-key read port.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   Start           one-cycle request to expand Key in Mode
//   Mode[1:0]       0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved (ModeErr)
//   Key[0:32*NK_MAX-1]  key, MSB-first and left-aligned; only the first Nk words are used
//   RoundIdx[3:0]   round-key read index, sampled every edge
//   RoundKey[0:127] words w[4r]..w[4r+3]; 1-cycle latency from RoundIdx
//   RoundKeyValid   RoundKey holds a round key of the finished schedule
//   Busy            high while in EXPAND
//   KeyReady        a complete schedule is stored
//   Done            one-cycle pulse when expansion completes
//   ModeErr         one-cycle pulse when Start arrives with Mode 3
//   state_dbg[1:0]  current FSM state (IDLE=0, EXPAND=1, READY=2)
//
// Handshake: Start is a single-cycle request, taken on the edge where it is high
// in IDLE or READY; it is not acknowledged and is dropped silently in EXPAND.
module key_expansion_seq #(
  parameter int Nb     = 4,
  parameter int NK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [1:0]            Mode,
  input  logic [0:32*NK_MAX-1]  Key,
  input  logic [3:0]            RoundIdx,
  output logic [0:127]          RoundKey,
  output logic                  RoundKeyValid,
  output logic                  Busy,
  output logic                  KeyReady,
  output logic                  Done,
  output logic                  ModeErr,
  output logic [1:0]            state_dbg
);

  // Schedule holds Nb*(Nr+1) words; Nr = Nk+6 at its largest.
  localparam int W_DEPTH = Nb * (NK_MAX + 7);
  localparam int IW      = $clog2(W_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

  // FIPS-197 S-box, entry 0 leftmost.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'd1:    return 4'd12;
      2'd2:    return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     w [W_DEPTH];
  logic [IW-1:0]   i_q;
  logic [3:0]      imod_q;   // i mod Nk, wrapping counter
  logic [7:0]      rcon_q;
  logic [1:0]      mode_q;

  logic            accept;
  logic            last_word;
  logic [3:0]      nk, nr;
  logic [31:0]     prev_w, old_w, sub_w, temp, new_w;
  logic [IW-1:0]   rd_base;

  assign nk        = nk_of(mode_q);
  assign nr        = nr_of(mode_q);
  assign accept    = Start && (Mode != 2'd3) && (state_q != EXPAND);
  // Last word index is Nb*(Nr+1)-1.
  assign last_word = (i_q == IW'(Nb * (int'(nr) + 1) - 1));
  assign rd_base   = IW'({RoundIdx, 2'b00});
  assign Busy      = (state_q == EXPAND);
  assign state_dbg = state_q;

  // Next schedule word. SubWord commutes with RotWord, so one set of four
  // S-box lookups serves both the i mod Nk = 0 and the Nk = 8, i mod 8 = 4 cases.
  always_comb begin
    prev_w = w[i_q - IW'(1)];
    old_w  = w[i_q - IW'(nk)];
    sub_w  = sub_word(prev_w);
    temp   = prev_w;
    if (imod_q == 4'd0)
      temp = {sub_w[23:0], sub_w[31:24]} ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && imod_q == 4'd4)
      temp = sub_w;
    new_w = old_w ^ temp;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, READY: if (accept) state_d = EXPAND;
      EXPAND:      if (last_word) state_d = READY;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q           <= '0;
      imod_q        <= '0;
      rcon_q        <= '0;
      mode_q        <= '0;
      KeyReady      <= 1'b0;
      Done          <= 1'b0;
      ModeErr       <= 1'b0;
      RoundKeyValid <= 1'b0;
      RoundKey      <= '0;
    end else begin
      Done    <= 1'b0;
      ModeErr <= Start && (Mode == 2'd3) && (state_q != EXPAND);

      if (accept) begin
        mode_q   <= Mode;
        i_q      <= IW'(nk_of(Mode));
        imod_q   <= '0;
        rcon_q   <= 8'h01;
        KeyReady <= 1'b0;
      end else if (state_q == EXPAND) begin
        i_q    <= i_q + IW'(1);
        imod_q <= (imod_q == nk - 4'd1) ? 4'd0 : imod_q + 4'd1;
        if (imod_q == 4'd0)
          rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (last_word) begin
          Done     <= 1'b1;
          KeyReady <= 1'b1;
        end
      end

      // A fresh Start invalidates the schedule on the same edge it is taken.
      if (KeyReady && !accept && RoundIdx <= nr) begin
        RoundKey      <= {w[rd_base], w[rd_base + IW'(1)],
                          w[rd_base + IW'(2)], w[rd_base + IW'(3)]};
        RoundKeyValid <= 1'b1;
      end else begin
        RoundKeyValid <= 1'b0;
      end
    end
  end

  // Word store needs no reset: KeyReady gates every read of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NK_MAX; k++)
        if (k < int'(nk_of(Mode)))
          w[k] <= Key[32*k +: 32];
    end else if (state_q == EXPAND) begin
      w[i_q] <= new_w;
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Testbench for key_expansion_seq: table of round-key reads against FIPS-197
// vectors, plus hand sequences for reserved mode, restart, ignored Start and
// mid-expansion reset.
module tb_key_expansion_seq;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           Start;
  logic [1:0]     Mode;
  logic [0:255]   Key;
  logic [3:0]     RoundIdx;
  logic [0:127]   RoundKey;
  logic           RoundKeyValid, Busy, KeyReady, Done, ModeErr;
  logic [1:0]     state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:127] last_rk;
  logic [0:255] key_tab [3];

  typedef struct {
    logic [1:0]   mode;
    logic [3:0]   idx;
    logic         valid;
    logic [0:127] rk;
  } vec_t;
  vec_t vecs [11];

  key_expansion_seq #(.Nb(4), .NK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Mode(Mode), .Key(Key),
    .RoundIdx(RoundIdx), .RoundKey(RoundKey), .RoundKeyValid(RoundKeyValid),
    .Busy(Busy), .KeyReady(KeyReady), .Done(Done), .ModeErr(ModeErr),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expansion run: Start on a negedge, count edges until Done.
  task automatic expand(input logic [1:0] m, input bit inject);
    int n;
    int busy_cnt;
    int cyc;
    cyc = (m == 2'd0) ? 40 : (m == 2'd1) ? 46 : 52;
    @(negedge clk);
    Start = 1'b1; Mode = m; Key = key_tab[m];
    @(posedge clk); #1;
    Start = 1'b0;
    RoundIdx = 4'hf;
    check("accept_busy", Busy, 1);
    check("accept_keyready", KeyReady, 0);
    check("accept_rkvalid", RoundKeyValid, 0);
    check("accept_rk_hold", RoundKey, last_rk);
    busy_cnt = Busy ? 1 : 0;
    n = 0;
    while (Done !== 1'b1 && n < 200) begin
      if (inject && n == 10) begin
        Start = 1'b1; Mode = 2'd1; Key = key_tab[1];
      end else begin
        Start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (Busy) busy_cnt++;
    end
    Start = 1'b0;
    check("done_latency", n + 1, cyc + 1);
    check("busy_cycles", busy_cnt, cyc);
    check("ready_keyready", KeyReady, 1);
    check("ready_state", state_dbg, 2);
    @(posedge clk); #1;
    check("done_pulse", Done, 0);
  endtask

  task automatic read(input logic [3:0] idx, input logic v, input logic [0:127] rk);
    @(negedge clk);
    RoundIdx = idx;
    @(posedge clk); #1;
    check($sformatf("rkvalid_idx%0d", idx), RoundKeyValid, v);
    if (v) last_rk = rk;
    check($sformatf("roundkey_idx%0d", idx), RoundKey, last_rk);
  endtask

  initial begin
    logic [1:0] cur_mode;
    // Unused key tail filled with junk: it must be ignored.
    key_tab[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefdeadbeefdeadbeefdeadbeef};
    key_tab[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeefdeadbeef};
    key_tab[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    vecs[0]  = '{2'd0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1]  = '{2'd0, 4'd0,  1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[2]  = '{2'd0, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3]  = '{2'd0, 4'd11, 1'b0, 128'h0};
    vecs[4]  = '{2'd1, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202};
    vecs[5]  = '{2'd1, 4'd13, 1'b0, 128'h0};
    vecs[6]  = '{2'd1, 4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[7]  = '{2'd2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e};
    vecs[8]  = '{2'd2, 4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781};
    vecs[9]  = '{2'd2, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4};
    vecs[10] = '{2'd2, 4'd15, 1'b0, 128'h0};

    // Reset
    rst_n = 1'b0; Start = 1'b0; Mode = 2'd0; Key = '0; RoundIdx = 4'hf;
    last_rk = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_keyready", KeyReady, 0);
    check("rst_done", Done, 0);
    check("rst_modeerr", ModeErr, 0);
    check("rst_rkvalid", RoundKeyValid, 0);
    check("rst_roundkey", RoundKey, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_state", state_dbg, 0);
    check("idle_busy", Busy, 0);

    // Reserved mode from IDLE
    @(negedge clk);
    Start = 1'b1; Mode = 2'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    check("idle_m3_modeerr", ModeErr, 1);
    check("idle_m3_busy", Busy, 0);
    check("idle_m3_state", state_dbg, 0);
    @(posedge clk); #1;
    check("idle_m3_pulse", ModeErr, 0);
    check("idle_m3_busy2", Busy, 0);

    // Table of reads, expanding whenever the mode changes
    cur_mode = 2'd3;
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].mode != cur_mode) begin
        expand(vecs[v].mode, 1'b0);
        cur_mode = vecs[v].mode;
      end
      read(vecs[v].idx, vecs[v].valid, vecs[v].rk);
    end

    // Reserved mode in READY keeps the AES-256 result readable
    read(4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
    @(negedge clk);
    Start = 1'b1; Mode = 2'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    check("ready_m3_modeerr", ModeErr, 1);
    check("ready_m3_busy", Busy, 0);
    check("ready_m3_keyready", KeyReady, 1);
    check("ready_m3_rkvalid", RoundKeyValid, 1);
    check("ready_m3_roundkey", RoundKey, last_rk);
    @(posedge clk); #1;
    check("ready_m3_pulse", ModeErr, 0);
    check("ready_m3_busy2", Busy, 0);
    check("ready_m3_roundkey2", RoundKey, 128'hfe4890d1e6188d0b046df344706c631e);

    // Restart from READY (RoundIdx still valid at the accepting edge),
    // with a second Start injected mid-expansion
    expand(2'd0, 1'b1);
    read(4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset at EXPAND cycle 20
    @(negedge clk);
    Start = 1'b1; Mode = 2'd0; Key = key_tab[0];
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    last_rk = '0;
    check("midrst_busy", Busy, 0);
    check("midrst_keyready", KeyReady, 0);
    check("midrst_done", Done, 0);
    check("midrst_modeerr", ModeErr, 0);
    check("midrst_rkvalid", RoundKeyValid, 0);
    check("midrst_roundkey", RoundKey, 0);
    check("midrst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_keyready", KeyReady, 0);
    expand(2'd0, 1'b0);
    read(4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read(4'd0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_expansion_seq.md
KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

Interface
REQ-001 The block SHALL have parameter Nb, default 4, meaning words per block (fixed 4 for AES).
REQ-002 The block SHALL have parameter NK_MAX, default 8, meaning the largest supported key length in words; the Key port width and word-store depth derive from it.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning an asynchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit, meaning a one-cycle request to expand Key in Mode.
REQ-006 The block SHALL have port Mode, input, 2 bits, meaning key size: 0 = AES-128 (Nk 4, Nr 10), 1 = AES-192 (Nk 6, Nr 12), 2 = AES-256 (Nk 8, Nr 14), 3 = reserved.
REQ-007 The block SHALL have port Key, input, 32*NK_MAX bits [0:32*NK_MAX-1], meaning the key, MSB-first and left-aligned; bits beyond 32*Nk are ignored.
REQ-008 The block SHALL have port RoundIdx, input, 4 bits, meaning the round-key read index 0..Nr.
REQ-009 The block SHALL have port RoundKey, output, 128 bits [0:127], meaning words w[4r]..w[4r+3], with w[4r] in bits [0:31].
REQ-010 The block SHALL have ports RoundKeyValid, Busy, KeyReady, Done and ModeErr, each output, 1 bit.

Function
REQ-011 The FSM SHALL have states IDLE, EXPAND and READY.
REQ-012 Start accepted in IDLE or READY with Mode 0..2 SHALL, in one edge: copy Key words 0..Nk-1 into store w[0..Nk-1], latch Mode, set i = Nk, set rcon = 8'h01, clear KeyReady, and enter EXPAND.
REQ-013 Start with Mode 3 SHALL pulse ModeErr for one cycle, leave the state and store unchanged, and not begin expansion.
REQ-014 Start while in EXPAND SHALL be ignored.
REQ-015 EXPAND SHALL produce exactly one word per cycle, w[i] = w[i-Nk] ^ temp, where temp = w[i-1] is transformed as follows.
REQ-016 When i mod Nk = 0, temp SHALL be SubWord(RotWord(temp)) ^ {rcon, 24'h0}, and rcon SHALL then update to xtime(rcon), i.e. a left shift, XORed with 8'h1b if the old bit 7 was set.
REQ-017 When Nk = 8 and i mod 8 = 4, temp SHALL be SubWord(temp); otherwise temp SHALL be w[i-1] unmodified.
REQ-018 SubWord SHALL apply the FIPS-197 S-box to each of the 4 bytes; rcon SHALL be computed sequentially, with no lookup table.
REQ-019 i mod Nk SHALL be tracked by a wrapping counter 0..Nk-1, not a divider.
REQ-020 After writing w[4*(Nr+1)-1], the FSM SHALL enter READY, pulse Done for one cycle, and set KeyReady high.
REQ-021 Expansion SHALL take 40 / 46 / 52 EXPAND cycles for Mode 0 / 1 / 2, with Done asserted on the cycle after the last write.
REQ-022 Busy SHALL be high exactly while in EXPAND.
REQ-023 The read port SHALL be registered with 1-cycle latency: RoundKey and RoundKeyValid reflect the RoundIdx sampled on the previous edge.
REQ-024 RoundKeyValid SHALL be 1 only when KeyReady = 1 and the sampled RoundIdx <= Nr; otherwise RoundKeyValid = 0 and RoundKey holds its last value.
REQ-025 A new accepted Start in READY SHALL drop KeyReady and RoundKeyValid on the following edge.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE; Busy, KeyReady, Done, ModeErr and RoundKeyValid to 0; RoundKey to 0; and i and rcon to 0.
REQ-027 Reset during EXPAND SHALL abort expansion; store contents are don't-care, and KeyReady stays 0 until a full expansion completes.
REQ-028 Release of rst_n SHALL need no Start handshake; the block waits in IDLE.

Verification
REQ-029 Mode 0, Key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> Done 41 cycles after Start, RoundIdx 10 -> RoundKey d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-030 Mode 1, Key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> RoundIdx 12 -> e98ba06f 448c773c 8ecc7204 01002202; RoundIdx 13 -> RoundKeyValid 0.
REQ-031 Mode 2, Key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> RoundIdx 14 -> fe4890d1 e6188d0b 046df344 706c631e; RoundIdx 0 -> the first four key words.
REQ-032 Start with Mode 3 -> single ModeErr pulse, Busy remains 0, and a prior READY result is still readable unchanged.
REQ-033 Second Start pulse mid-EXPAND -> ignored; results match REQ-029; Busy high for exactly 40 cycles.
REQ-034 rst_n pulsed low at EXPAND cycle 20 -> all outputs 0 immediately; a following Mode 0 Start reproduces REQ-029.
